// File: rtl/rvfi_commit_ctrl.sv
// RVFI capture-array sequencer: in-order allocation, round-robin writeback
// arbitration onto the single write port, and in-order retirement with order stamps.
module rvfi_commit_ctrl #(
    parameter  int unsigned ARR_DEPTH = 16,
    parameter  int unsigned N_WB      = 3,
    localparam int unsigned IDX_W     = $clog2(ARR_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    output logic [IDX_W-1:0]        alloc_idx,
    input  logic [N_WB-1:0]         wb_req,
    input  logic [N_WB*IDX_W-1:0]   wb_idx,
    output logic [N_WB-1:0]         wb_gnt,
    output logic                    arr_we,
    output logic [IDX_W-1:0]        arr_idx_in,
    output logic                    arr_read_enable,
    output logic [IDX_W-1:0]        arr_idx_out,
    input  logic                    commit_stall,
    input  logic                    flush,
    output logic                    commit_valid,
    output logic [63:0]             commit_order,
    output logic [IDX_W:0]          count
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned RR_W  = (N_WB > 1) ? $clog2(N_WB) : 1;

    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ARR_DEPTH-1:0] alloc_bit_q, alloc_bit_d;
    logic [ARR_DEPTH-1:0] done_bit_q, done_bit_d;
    logic [63:0]          order_q, order_d;
    logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 gnt_found;
    logic [RR_W-1:0]      gnt_off;
    logic [RR_W:0]        gnt_sum;
    logic [RR_W-1:0]      gnt_unit;
    logic [N_WB-1:0]      req_rot;
    logic                 alloc_hs;
    logic                 fire;

    // Round-robin: rotate requests so rr_ptr sits at bit 0, take the first set bit.
    always_comb begin
        req_rot   = N_WB'({wb_req, wb_req} >> rr_ptr_q);
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int i = 0; i < N_WB; i++) begin
            if (!gnt_found && req_rot[i]) begin
                gnt_found = 1'b1;
                gnt_off   = RR_W'(i);
            end
        end
        if (flush) begin
            gnt_found = 1'b0;
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= (RR_W+1)'(N_WB)) begin
            gnt_sum = gnt_sum - (RR_W+1)'(N_WB);
        end
        gnt_unit   = RR_W'(gnt_sum);
        wb_gnt     = '0;
        arr_idx_in = '0;
        for (int k = 0; k < N_WB; k++) begin
            if (gnt_found && gnt_unit == RR_W'(k)) begin
                wb_gnt[k]  = 1'b1;
                arr_idx_in = wb_idx[k*IDX_W +: IDX_W];
            end
        end
        arr_we = gnt_found;
    end

    // Allocation and commit decisions; readiness looks only at registered count.
    always_comb begin
        alloc_ready     = (count_q != CNT_W'(ARR_DEPTH)) && !flush;
        alloc_hs        = alloc_valid && alloc_ready;
        fire            = (count_q != '0) && done_bit_q[head_q] && !commit_stall && !flush;
        alloc_idx       = tail_q;
        arr_idx_out     = head_q;
        arr_read_enable = fire;
        commit_valid    = fire;
        commit_order    = order_q;
        count           = count_q;
    end

    // Next-state: writeback completion, then retirement, then allocation.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        alloc_bit_d = alloc_bit_q;
        done_bit_d  = done_bit_q;
        order_d     = order_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_found) begin
            rr_ptr_d = (gnt_unit == RR_W'(N_WB - 1)) ? '0 : gnt_unit + RR_W'(1);
        end
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            alloc_bit_d = '0;
            done_bit_d  = '0;
        end else begin
            // A stale writer still owns the write port but cannot complete a free entry.
            if (arr_we && alloc_bit_q[arr_idx_in]) begin
                done_bit_d[arr_idx_in] = 1'b1;
            end
            if (fire) begin
                alloc_bit_d[head_q] = 1'b0;
                done_bit_d[head_q]  = 1'b0;
                head_d              = head_q + IDX_W'(1);
                order_d             = order_q + 64'd1;
            end
            if (alloc_hs) begin
                alloc_bit_d[tail_q] = 1'b1;
                done_bit_d[tail_q]  = 1'b0;
                tail_d              = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_hs) - CNT_W'(fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alloc_bit_q <= '0;
            done_bit_q  <= '0;
            order_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            alloc_bit_q <= alloc_bit_d;
            done_bit_q  <= done_bit_d;
            order_q     <= order_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_rvfi_commit_ctrl.sv
// Randomized bench for rvfi_commit_ctrl against a queue-based model of in-flight entries.
module tb_rvfi_commit_ctrl;

    localparam int unsigned D  = 16;
    localparam int unsigned N  = 3;
    localparam int unsigned IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [IW-1:0]   alloc_idx;
    logic [N-1:0]    wb_req;
    logic [N*IW-1:0] wb_idx;
    logic [N-1:0]    wb_gnt;
    logic            arr_we;
    logic [IW-1:0]   arr_idx_in;
    logic            arr_read_enable;
    logic [IW-1:0]   arr_idx_out;
    logic            commit_stall;
    logic            flush;
    logic            commit_valid;
    logic [63:0]     commit_order;
    logic [IW:0]     count;

    rvfi_commit_ctrl #(.ARR_DEPTH(D), .N_WB(N)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_req(wb_req), .wb_idx(wb_idx), .wb_gnt(wb_gnt),
        .arr_we(arr_we), .arr_idx_in(arr_idx_in),
        .arr_read_enable(arr_read_enable), .arr_idx_out(arr_idx_out),
        .commit_stall(commit_stall), .flush(flush),
        .commit_valid(commit_valid), .commit_order(commit_order), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int idx;
        bit done;
    } ent_t;

    ent_t            q[$];
    int              tail;
    int              rr;
    longint unsigned order;
    bit              pend[N];
    int              pidx[N];
    bit              saw_full;
    int              fires;

    task automatic model_clear(input bit keep_order);
        q.delete();
        tail = 0;
        if (!keep_order) begin
            order = 0;
            rr    = 0;
            for (int k = 0; k < N; k++) pend[k] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        alloc_valid  = 1'b0;
        commit_stall = 1'b0;
        flush        = 1'b0;
        wb_req       = '0;
        wb_idx       = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b0);
        #1;
        check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check_eq("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        check_eq("rst_wb_gnt", 64'(wb_gnt), 64'd0);
        check_eq("rst_arr_we", 64'(arr_we), 64'd0);
        check_eq("rst_read_en", 64'(arr_read_enable), 64'd0);
        check_eq("rst_commit_valid", 64'(commit_valid), 64'd0);
        check_eq("rst_commit_order", commit_order, 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
    endtask

    // One cycle: pa/pw/ps in percent, pf in per-mille.
    task automatic step(input int pa, input int pw, input int ps, input int pf);
        int  g;
        int  k;
        int  head;
        bit  fire;
        bit  hs;
        @(negedge clk);
        alloc_valid  = ($urandom_range(99) < pa);
        commit_stall = ($urandom_range(99) < ps);
        flush        = ($urandom_range(999) < pf);
        for (int u = 0; u < N; u++) begin
            if (!pend[u] && $urandom_range(99) < pw) begin
                pend[u] = 1'b1;
                if (q.size() > 0 && $urandom_range(9) != 0)
                    pidx[u] = q[$urandom_range(q.size() - 1)].idx;
                else
                    pidx[u] = $urandom_range(D - 1);
            end
            wb_req[u]         = pend[u];
            wb_idx[u*IW +: IW] = IW'(pidx[u]);
        end
        #1;
        g = -1;
        if (!flush) begin
            for (int i = 0; i < N; i++) begin
                k = (rr + i) % N;
                if (g < 0 && pend[k]) g = k;
            end
        end
        head = (tail - q.size() + D) % D;
        fire = (q.size() != 0) && q[0].done && !commit_stall && !flush;
        hs   = alloc_valid && (q.size() < D) && !flush;
        if (q.size() == D) saw_full = 1'b1;

        check_eq("alloc_ready", 64'(alloc_ready), 64'((q.size() < D) && !flush));
        check_eq("alloc_idx", 64'(alloc_idx), 64'(tail));
        check_eq("wb_gnt", 64'(wb_gnt), (g < 0) ? 64'd0 : (64'd1 << g));
        check_eq("arr_we", 64'(arr_we), 64'(g >= 0));
        if (g >= 0) check_eq("arr_idx_in", 64'(arr_idx_in), 64'(pidx[g]));
        check_eq("commit_valid", 64'(commit_valid), 64'(fire));
        check_eq("read_enable", 64'(arr_read_enable), 64'(fire));
        check_eq("arr_idx_out", 64'(arr_idx_out), 64'(head));
        check_eq("count", 64'(count), 64'(q.size()));
        if (fire) check_eq("commit_order", commit_order, order);

        @(posedge clk);
        if (flush) begin
            model_clear(1'b1);
        end else begin
            if (g >= 0) begin
                for (int j = 0; j < q.size(); j++)
                    if (q[j].idx == pidx[g]) q[j].done = 1'b1;
            end
            if (fire) begin
                void'(q.pop_front());
                order++;
                fires++;
            end
            if (hs) begin
                q.push_back('{idx: tail, done: 1'b0});
                tail = (tail + 1) % D;
            end
        end
        if (g >= 0) begin
            rr      = (g + 1) % N;
            pend[g] = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        saw_full = 1'b0;
        fires    = 0;
        drive_idle();
        model_clear(1'b0);
        repeat (2) @(posedge clk);
        do_reset();

        for (int c = 0; c < 400; c++) step(70, 30, 20, 5);
        for (int c = 0; c < 400; c++) step(90, 5, 50, 0);
        for (int c = 0; c < 400; c++) step(30, 60, 10, 20);
        do_reset();
        for (int c = 0; c < 400; c++) step(80, 40, 30, 10);
        for (int c = 0; c < 300; c++) step(95, 3, 60, 0);
        for (int c = 0; c < 300; c++) step(50, 50, 20, 15);

        check_eq("saw_full", 64'(saw_full), 64'd1);
        check_eq("fires_seen", 64'(fires > 50), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
